// File: rtl/voice_allocator_if.sv
// Event handshake bundle between a note-event source and the voice allocator.
// Member names keep the allocator's port naming so either side reads naturally.
interface voice_allocator_if;
  logic       i_ev_valid;
  logic       o_ev_ready;
  logic       i_ev_on;
  logic [6:0] i_ev_note;

  // Event producer side
  modport master (
    output i_ev_valid,
    output i_ev_on,
    output i_ev_note,
    input  o_ev_ready
  );

  // Allocator side
  modport slave (
    input  i_ev_valid,
    input  i_ev_on,
    input  i_ev_note,
    output o_ev_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler. Note-on/off events update a voice table with the
// policy: reuse matching note, else lowest free voice, else steal the oldest.
// The table is presented one voice per clk_en in step with the phase bank,
// whose bank index also starts at NVOICES-1 after reset.
module voice_allocator #(
  parameter int NVOICES = 10,
  parameter int SLOT_W  = 4,
  parameter int AGE_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  voice_allocator_if.slave  ev,
  output logic [6:0]        o_midi,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_frame_start,
  output logic [SLOT_W-1:0] o_active_cnt,
  output logic              o_steal
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NVOICES - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX   = {AGE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Voice table and per-voice age (0 = most recently allocated/retriggered)
  logic [6:0]       table_q [NVOICES];
  logic [6:0]       table_d [NVOICES];
  logic [AGE_W-1:0] age_q   [NVOICES];
  logic [AGE_W-1:0] age_d   [NVOICES];

  logic [NVOICES-1:0] active_vec;   // voice holds a non-zero note
  logic [NVOICES-1:0] younger_vec;  // voice is younger than the matched voice

  // Latched event and scan results
  logic              ev_on_q;
  logic [6:0]        ev_note_q;
  logic [SLOT_W-1:0] idx_q;
  logic              match_found_q;
  logic [SLOT_W-1:0] match_idx_q;
  logic              free_found_q;
  logic [SLOT_W-1:0] free_idx_q;
  logic              oldest_found_q;
  logic [SLOT_W-1:0] oldest_idx_q;
  logic [AGE_W-1:0]  oldest_age_q;
  logic [SLOT_W-1:0] target_idx;

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] active_cnt_q, active_cnt_d;
  logic              steal_q, steal_d;
  logic              accept;

  assign accept = ev.i_ev_valid & ev.o_ev_ready;

  for (genvar gi = 0; gi < NVOICES; gi++) begin : g_voice
    assign active_vec[gi]  = (table_q[gi] != 7'd0);
    assign younger_vec[gi] = (age_q[gi] < age_q[match_idx_q]);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: zero notes are swallowed without leaving IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && (ev.i_ev_note != 7'd0)) state_d = SCAN;
      SCAN:    if (idx_q == LAST_SLOT) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: events are only taken while idle
  always_comb begin
    ev.o_ev_ready = (state_q == IDLE);
  end

  // Event latch and one-voice-per-clock scan of the table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_on_q        <= 1'b0;
      ev_note_q      <= '0;
      idx_q          <= '0;
      match_found_q  <= 1'b0;
      match_idx_q    <= '0;
      free_found_q   <= 1'b0;
      free_idx_q     <= '0;
      oldest_found_q <= 1'b0;
      oldest_idx_q   <= '0;
      oldest_age_q   <= '0;
    end else if (accept) begin
      ev_on_q        <= ev.i_ev_on;
      ev_note_q      <= ev.i_ev_note;
      idx_q          <= '0;
      match_found_q  <= 1'b0;
      free_found_q   <= 1'b0;
      oldest_found_q <= 1'b0;
    end else if (state_q == SCAN) begin
      idx_q <= idx_q + 1'b1;
      if (!match_found_q && (table_q[idx_q] == ev_note_q)) begin
        match_found_q <= 1'b1;
        match_idx_q   <= idx_q;
      end
      if (!free_found_q && (table_q[idx_q] == 7'd0)) begin
        free_found_q <= 1'b1;
        free_idx_q   <= idx_q;
      end
      // Strictly-greater keeps the lowest index on equal ages
      if ((table_q[idx_q] != 7'd0) &&
          (!oldest_found_q || (age_q[idx_q] > oldest_age_q))) begin
        oldest_found_q <= 1'b1;
        oldest_idx_q   <= idx_q;
        oldest_age_q   <= age_q[idx_q];
      end
    end
  end

  assign target_idx = free_found_q ? free_idx_q : oldest_idx_q;

  // Table/age update applied on the COMMIT cycle
  always_comb begin
    steal_d = 1'b0;
    for (int i = 0; i < NVOICES; i++) begin
      table_d[i] = table_q[i];
      age_d[i]   = age_q[i];
    end
    if (state_q == COMMIT) begin
      if (ev_on_q && match_found_q) begin
        // Retrigger: voices younger than the match shift up by one
        for (int i = 0; i < NVOICES; i++) begin
          if ((SLOT_W'(i) != match_idx_q) && active_vec[i] && younger_vec[i]) begin
            age_d[i] = age_q[i] + 1'b1;
          end
        end
        age_d[match_idx_q] = '0;
      end else if (ev_on_q) begin
        // Allocate free voice, or steal the oldest when none is free
        for (int i = 0; i < NVOICES; i++) begin
          if (active_vec[i] && (age_q[i] != AGE_MAX)) begin
            age_d[i] = age_q[i] + 1'b1;
          end
        end
        table_d[target_idx] = ev_note_q;
        age_d[target_idx]   = '0;
        steal_d             = ~free_found_q;
      end else if (match_found_q) begin
        table_d[match_idx_q] = 7'd0;
        age_d[match_idx_q]   = '0;
      end
    end
  end

  // Count of sounding voices after this cycle's update
  always_comb begin
    active_cnt_d = '0;
    for (int i = 0; i < NVOICES; i++) begin
      if (table_d[i] != 7'd0) active_cnt_d = active_cnt_d + 1'b1;
    end
  end

  // Voice table, ages, active count and steal pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NVOICES; i++) begin
        table_q[i] <= '0;
        age_q[i]   <= '0;
      end
      active_cnt_q <= '0;
      steal_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NVOICES; i++) begin
        table_q[i] <= table_d[i];
        age_q[i]   <= age_d[i];
      end
      active_cnt_q <= active_cnt_d;
      steal_q      <= steal_d;
    end
  end

  // Presentation slot, advancing with the phase bank on each clk_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= LAST_SLOT;
    end else if (clk_en) begin
      slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    end
  end

  assign o_slot        = slot_q;
  assign o_midi        = table_q[slot_q];
  assign o_frame_start = (slot_q == '0);
  assign o_active_cnt  = active_cnt_q;
  assign o_steal       = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a reference voice-policy model and
// a scoreboard of expected per-event results.
module tb_voice_allocator;
  localparam int NV  = 10;
  localparam int LAT = NV + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [6:0] midi;
  logic [3:0] slot;
  logic       frame_start;
  logic [3:0] active_cnt;
  logic       steal;

  voice_allocator_if ev_if();

  voice_allocator #(.NVOICES(NV), .SLOT_W(4), .AGE_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .ev            (ev_if),
    .o_midi        (midi),
    .o_slot        (slot),
    .o_frame_start (frame_start),
    .o_active_cnt  (active_cnt),
    .o_steal       (steal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [69:0] tbl;
    logic [3:0]  cnt;
    logic [1:0]  steals;
    logic [5:0]  lat;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] m_tbl [NV];
  int         m_age [NV];
  logic [6:0] obs_tbl [NV];

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_tbl[i] = 7'd0;
      m_age[i] = 0;
    end
  endtask

  // Reference voice policy
  task automatic model(input logic on, input logic [6:0] note, output bit stole);
    int match, free, oldest, oa, old, tgt;
    match = -1; free = -1; oldest = -1; oa = -1;
    stole = 1'b0;
    if (note == 7'd0) return;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_tbl[i] == note) match = i;
      if (free < 0 && m_tbl[i] == 7'd0) free = i;
      if (m_tbl[i] != 7'd0 && m_age[i] > oa) begin
        oa = m_age[i];
        oldest = i;
      end
    end
    if (on) begin
      if (match >= 0) begin
        old = m_age[match];
        for (int i = 0; i < NV; i++)
          if (i != match && m_tbl[i] != 7'd0 && m_age[i] < old) m_age[i]++;
        m_age[match] = 0;
      end else begin
        tgt   = (free >= 0) ? free : oldest;
        stole = (free < 0);
        for (int i = 0; i < NV; i++)
          if (i != tgt && m_tbl[i] != 7'd0 && m_age[i] < 15) m_age[i]++;
        m_tbl[tgt] = note;
        m_age[tgt] = 0;
      end
    end else if (match >= 0) begin
      m_tbl[match] = 7'd0;
      m_age[match] = 0;
    end
  endtask

  function automatic logic [69:0] pack_model();
    logic [69:0] p;
    for (int i = 0; i < NV; i++) p[i*7 +: 7] = m_tbl[i];
    return p;
  endfunction

  function automatic logic [69:0] pack_obs();
    logic [69:0] p;
    for (int i = 0; i < NV; i++) p[i*7 +: 7] = obs_tbl[i];
    return p;
  endfunction

  function automatic logic [3:0] model_cnt();
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NV; i++) if (m_tbl[i] != 7'd0) c = c + 4'd1;
    return c;
  endfunction

  // Walk all slots with clk_en and capture o_midi per slot
  task automatic read_table();
    clk_en = 1'b1;
    for (int k = 0; k < NV; k++) begin
      tick();
      obs_tbl[slot] = midi;
    end
    clk_en = 1'b0;
  endtask

  // Drive one event, wait for completion, then check against the scoreboard
  task automatic send(input logic on, input logic [6:0] note);
    exp_t e, got;
    bit   stole;
    int   lat, nst;
    model(on, note, stole);
    e.tbl    = pack_model();
    e.cnt    = model_cnt();
    e.steals = {1'b0, stole};
    e.lat    = (note == 7'd0) ? 6'd0 : 6'(LAT);
    sb_q.push_back(e);

    ev_if.i_ev_valid = 1'b1;
    ev_if.i_ev_on    = on;
    ev_if.i_ev_note  = note;
    chk("ready_before_accept", ev_if.o_ev_ready, 1);
    tick();
    ev_if.i_ev_valid = 1'b0;
    ev_if.i_ev_on    = 1'($urandom_range(0, 1));
    ev_if.i_ev_note  = 7'($urandom_range(0, 127));

    lat = 0;
    nst = 0;
    while (ev_if.o_ev_ready !== 1'b1 && lat < 40) begin
      nst += int'(steal);
      tick();
      lat++;
    end
    nst += int'(steal);
    tick();
    nst += int'(steal);
    got.cnt    = active_cnt;
    got.lat    = 6'(lat);
    got.steals = 2'(nst);
    read_table();
    got.tbl = pack_obs();

    e = sb_q.pop_front();
    chk($sformatf("latency on=%0d note=%0d", on, note), got.lat, e.lat);
    chk($sformatf("steal_pulses on=%0d note=%0d", on, note), got.steals, e.steals);
    chk($sformatf("active_cnt on=%0d note=%0d", on, note), got.cnt, e.cnt);
    chk($sformatf("table on=%0d note=%0d", on, note), got.tbl, e.tbl);
    $display("event on=%0d note=%0d lat=%0d steals=%0d cnt=%0d table=%h",
             on, note, lat, nst, got.cnt, got.tbl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int dups;
    rst              = 1'b1;
    clk_en           = 1'b0;
    ev_if.i_ev_valid = 1'b0;
    ev_if.i_ev_on    = 1'b0;
    ev_if.i_ev_note  = 7'd0;
    model_reset();

    // Reset state and first clk_en pulse
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_slot", slot, 9);
    chk("reset_ready", ev_if.o_ev_ready, 1);
    chk("reset_active_cnt", active_cnt, 0);
    chk("reset_steal", steal, 0);
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    chk("first_slot", slot, 0);
    chk("first_frame_start", frame_start, 1);
    chk("first_midi", midi, 0);
    chk("first_ready", ev_if.o_ev_ready, 1);

    // Allocation
    send(1'b1, 7'd60);
    send(1'b1, 7'd64);
    chk("alloc_v0", obs_tbl[0], 60);
    chk("alloc_v1", obs_tbl[1], 64);
    chk("alloc_cnt", active_cnt, 2);
    clk_en = 1'b1;
    for (int k = 0; k < 2 * NV; k++) begin
      tick();
      if (slot == 4'd0) chk("run_midi_slot0", midi, 60);
      if (slot == 4'd1) chk("run_midi_slot1", midi, 64);
      chk("run_frame_start", frame_start, (slot == 4'd0));
    end
    clk_en = 1'b0;

    // Release and re-allocate
    send(1'b0, 7'd60);
    chk("release_v0", obs_tbl[0], 0);
    send(1'b1, 7'd67);
    chk("realloc_v0", obs_tbl[0], 67);
    send(1'b0, 7'd99);
    chk("absent_off_cnt", active_cnt, 2);

    // Steal
    do_reset();
    for (int n = 40; n < 50; n++) send(1'b1, 7'(n));
    chk("full_cnt", active_cnt, 10);
    send(1'b1, 7'd72);
    chk("steal_v0", obs_tbl[0], 72);
    chk("steal_cnt", active_cnt, 10);

    // Retrigger then steal
    send(1'b1, 7'd41);
    send(1'b1, 7'd73);
    chk("retrig_v1", obs_tbl[1], 41);
    chk("retrig_v2", obs_tbl[2], 73);
    dups = 0;
    for (int i = 0; i < NV; i++)
      for (int j = i + 1; j < NV; j++)
        if (obs_tbl[i] != 7'd0 && obs_tbl[i] == obs_tbl[j]) dups++;
    chk("no_duplicates", dups, 0);

    // Mid-operation reset
    ev_if.i_ev_valid = 1'b1;
    ev_if.i_ev_on    = 1'b1;
    ev_if.i_ev_note  = 7'd50;
    tick();
    ev_if.i_ev_valid = 1'b0;
    repeat (3) tick();
    chk("busy_before_reset", ev_if.o_ev_ready, 0);
    rst = 1'b1;
    #1;
    chk("async_reset_slot", slot, 9);
    chk("async_reset_ready", ev_if.o_ev_ready, 1);
    chk("async_reset_cnt", active_cnt, 0);
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    read_table();
    chk("reset_table_clear", pack_obs(), 0);

    // Zero note is swallowed
    send(1'b1, 7'd55);
    send(1'b1, 7'd0);
    chk("zero_note_v0", obs_tbl[0], 55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice scheduler for the pipelined phase bank. It accepts note-on/note-off events over a valid/ready handshake and maintains a NVOICES-entry voice table using the policy: reuse matching note, else lowest free voice, else steal oldest. It presents the table time-multiplexed, one voice per clk_en, in lock-step with the phase bank's round-robin bank index. o_midi drives the phase bank's i_midi directly; both blocks share clk, clk_en and rst.

Parameters:
NVOICES, 10, number of voices; must equal the phase bank's NBANKS.
SLOT_W, 4, width of the slot index; must satisfy 2^SLOT_W >= NVOICES.
AGE_W, 4, per-voice age counter width; must satisfy 2^AGE_W >= NVOICES.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
clk_en  in  1  sample strobe, the same signal that feeds the phase bank.
i_ev_valid  in  1  event valid.
o_ev_ready  out  1  event ready; high only in IDLE.
i_ev_on  in  1  1 = note-on, 0 = note-off.
i_ev_note  in  7  MIDI note number.
o_midi  out  7  note of the voice at o_slot; 0 = silent. Connects to the phase bank's i_midi.
o_slot  out  SLOT_W  voice index currently presented.
o_frame_start  out  1  high while o_slot == 0.
o_active_cnt  out  SLOT_W  number of non-zero table entries.
o_steal  out  1  one-cycle pulse when a voice is stolen.

Behaviour:
- Reset (asynchronous):
  - voice table all 0; ages all 0; state = IDLE.
  - o_slot = NVOICES-1, matching the phase bank's post-reset index.
  - o_active_cnt = 0; o_steal = 0; o_ev_ready = 1.
- Slot sequencing:
  - On every clk with clk_en = 1, o_slot increments, wrapping from NVOICES-1 to 0. It holds when clk_en = 0.
  - o_midi = table[o_slot], read combinationally from registers, so the phase bank samples table[v] on the same edge it processes bank v.
  - Slot sequencing is independent of the event FSM.
- Handshake:
  - An event is accepted on a clk where i_ev_valid & o_ev_ready; it is latched on that edge.
  - i_ev_note == 0 is accepted and discarded; state stays IDLE.
- FSM:
  - IDLE: ready = 1. On accept of a note != 0, go to SCAN with idx = 0.
  - SCAN: ready = 0. Examine one voice per clk for idx = 0..NVOICES-1, tracking:
    - first voice whose note matches,
    - first free voice (note 0),
    - oldest active voice (max age, ties to lowest index).
    After idx = NVOICES-1, go to COMMIT.
  - COMMIT: ready = 0. Write the table (rules below), update o_active_cnt, go to IDLE.
  - Latency: accept at edge T, commit write at edge T+NVOICES+1, ready high again after that edge. Throughput is 1 event per NVOICES+2 clks.
- Note-on, in priority order:
  - match found: age[match] = 0; every other active voice with age < old age[match] increments; no allocation.
  - else free voice found: table[free] = note, age[free] = 0; every other active voice's age increments, saturating at 2^AGE_W-1.
  - else steal: table[oldest] = note, age[oldest] = 0; every other voice's age increments; o_steal = 1 for the cycle after COMMIT.
- Note-off:
  - match found: table[match] = 0, age[match] = 0.
  - no match: no-op.
- Ages of active voices are always distinct; the youngest voice has age 0.
- Table writes are independent of clk_en. A commit coinciding with a clk_en edge is seen by the phase bank only on that voice's next visit.
- Phase accumulators are not cleared on allocation or steal; this block does not touch them.
- Inputs i_ev_on and i_ev_note are ignored outside the accept cycle.
- Reset asserted mid-SCAN or mid-COMMIT aborts the event; the table is cleared.

Test Plan:
- Reset: release rst, then pulse clk_en once -> before the pulse o_slot = 9; after it o_slot = 0, o_frame_start = 1, o_midi = 0, o_ev_ready = 1.
- Allocation: note-on 60 then note-on 64 -> table[0] = 60, table[1] = 64; o_active_cnt = 2; o_ready low for exactly 11 clks after each accept; with free-running clk_en, o_midi = 60 when o_slot = 0 and 64 when o_slot = 1.
- Release: from the previous state, note-off 60 then note-on 67 -> table[0] = 0, then table[0] = 67; note-off 99 (absent) -> table unchanged, o_active_cnt = 2.
- Steal: note-on 40..49 (fills all 10), then note-on 72 -> table[0] = 72 (40 was oldest), o_steal pulses exactly once, o_active_cnt = 10.
- Retrigger: with 10 voices full, note-on 41 (voice 1), then note-on 73 -> table[1] still 41, 42 in voice 2 is stolen, table[2] = 73, no duplicates in the table.
- Mid-operation reset, plus note 0: assert rst 3 clks after accepting note-on 50 -> table all 0, o_slot = 9, FSM in IDLE. Note-on 0 -> accepted in 1 clk, ready never drops, table unchanged.
